// File: rtl/sr_pkg.sv
// Shared constants for the 74HC595-style serial writer: FSM encoding and default sizing.
package sr_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int CLK_DIV_DEF = 4;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT_LO = 2'd1;
  localparam logic [1:0] SHIFT_HI = 2'd2;
  localparam logic [1:0] LATCH    = 2'd3;
endpackage

// File: rtl/clk_div_tick.sv
// Phase timer: counts CLK_DIV cycles while enabled and emits a one-cycle tick on the last one.
module clk_div_tick
  import sr_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);
  localparam int              CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // The FSM only changes state on tick, so wrapping here restarts every phase at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/shift_reg_tx.sv
// Serial writer for a 74HC595 chain: shifts a captured word out on sr_data/sr_clk, then pulses sr_latch.
// Build option SR_LSB_FIRST_EN: send data[0] first instead of data[DATA_W-1].
module shift_reg_tx
  import sr_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              sr_data,
  output logic              sr_clk,
  output logic              sr_latch
);
  localparam int BW = $clog2(DATA_W + 1);

  logic [1:0]        state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              tick;
  logic              cur_bit;

  clk_div_tick #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state != IDLE),
    .tick    (tick)
  );

`ifdef SR_LSB_FIRST_EN
  assign cur_bit = shreg[0];
`else
  assign cur_bit = shreg[DATA_W-1];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SHIFT_LO;
      SHIFT_LO: if (tick)  state_nxt = SHIFT_HI;
      SHIFT_HI: if (tick)  state_nxt = (bitcnt == BW'(1)) ? LATCH : SHIFT_LO;
      LATCH:    if (tick)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        shreg  <= data;
        bitcnt <= BW'(DATA_W);
      end else if (state == SHIFT_HI && tick) begin
`ifdef SR_LSB_FIRST_EN
        shreg  <= shreg >> 1;
`else
        shreg  <= shreg << 1;
`endif
        bitcnt <= bitcnt - 1'b1;
      end
    end
  end

  // Pins are registered decodes of the current state, so they trail the FSM by one cycle;
  // done fires on the cycle busy drops, i.e. the first registered IDLE after a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sr_data  <= 1'b0;
      sr_clk   <= 1'b0;
      sr_latch <= 1'b0;
    end else begin
      busy     <= (state != IDLE);
      done     <= (state == IDLE) && busy;
      sr_clk   <= (state == SHIFT_HI);
      sr_latch <= (state == LATCH);
      if (state == SHIFT_LO) sr_data <= cur_bit;
    end
  end
endmodule

// File: tb/tb_shift_reg_tx.sv
// Directed bench for shift_reg_tx: 8-bit/div-2 instance plus a 1-bit/div-1 corner instance.
module tb_shift_reg_tx;
`ifdef SR_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] data;
  logic       busy, done, sr_data, sr_clk, sr_latch;
  logic       start1;
  logic [0:0] data1;
  logic       busy1, done1, sr_data1, sr_clk1, sr_latch1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_reg_tx #(.DATA_W(8), .CLK_DIV(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data(data),
    .busy(busy), .done(done), .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch)
  );

  shift_reg_tx #(.DATA_W(1), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .data(data1),
    .busy(busy1), .done(done1), .sr_data(sr_data1), .sr_clk(sr_clk1), .sr_latch(sr_latch1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ew(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return LSB ? r : d;
  endfunction

  // One transfer; k counts negedges after the accepting edge (k=0 is the first one).
  task automatic xfer(input logic [7:0] d, input int inj, output logic [7:0] word,
                      output int edges, output int lat_cyc, output int lat_pulses,
                      output int busy_cyc, output int done_at);
    logic pc, pl;
    word = '0; edges = 0; lat_cyc = 0; lat_pulses = 0; busy_cyc = 0; done_at = -1;
    pc = 1'b0; pl = 1'b0;
    @(negedge clk); start = 1'b1; data = d;
    @(posedge clk); #1 start = 1'b0; data = 8'h00;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == inj) begin start = 1'b1; data = 8'hFF; end
      else if (k == inj + 1) start = 1'b0;
      if (sr_clk && !pc) begin word = {word[6:0], sr_data}; edges++; end
      if (sr_latch) lat_cyc++;
      if (sr_latch && !pl) lat_pulses++;
      if (busy) busy_cyc++;
      pc = sr_clk; pl = sr_latch;
      if (done) begin done_at = k; break; end
    end
  endtask

  task automatic xfer_checks(input string t, input logic [7:0] d, input int inj);
    logic [7:0] w;
    int e, lc, lp, bc, da;
    xfer(d, inj, w, e, lc, lp, bc, da);
    chk({t, "_word"},    w,  ew(d));
    chk({t, "_edges"},   e,  8);
    chk({t, "_lat_cyc"}, lc, 2);
    chk({t, "_lat_n"},   lp, 1);
    chk({t, "_busy"},    bc, 34);
    chk({t, "_done_at"}, da, 35);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w16;
    logic        pc, b35, b36;
    int          e16, d1, d2, r2, lc, bc, hc;

    reset_n = 1'b0; start = 1'b0; data = '0; start1 = 1'b0; data1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs",  {busy, done, sr_data, sr_clk, sr_latch}, 5'b0);
    chk("rst_outs1", {busy1, done1, sr_data1, sr_clk1, sr_latch1}, 5'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs", {busy, done, sr_clk, sr_latch}, 4'b0);

    // 1: basic transfer
    xfer_checks("t1", 8'hA5, -10);
    repeat (3) @(negedge clk);

    // 2: start during transfer is ignored
    xfer_checks("t2", 8'h3C, 10);
    repeat (3) @(negedge clk);
    chk("t2_idle", {busy, sr_latch}, 2'b0);

    // 3: start held high -> back-to-back transfers
    w16 = '0; e16 = 0; d1 = -1; d2 = -1; r2 = -1; pc = 1'b0; b35 = 1'bx; b36 = 1'bx;
    @(negedge clk); start = 1'b1; data = 8'h01;
    @(posedge clk); #1 data = 8'h80;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (sr_clk && !pc) begin
        w16 = {w16[14:0], sr_data}; e16++;
        if (e16 == 9) r2 = k;
      end
      pc = sr_clk;
      if (k == 35) b35 = busy;
      if (k == 36) b36 = busy;
      if (done) begin
        if (d1 < 0) begin d1 = k; start = 1'b0; end
        else begin d2 = k; break; end
      end
    end
    chk("t3_done1", d1, 35);
    chk("t3_done2", d2, 70);
    chk("t3_edges", e16, 16);
    chk("t3_words", w16, {ew(8'h01), ew(8'h80)});
    chk("t3_gap",   {b35, b36}, 2'b01);
    chk("t3_rise2", r2, 38);
    repeat (3) @(negedge clk);

    // 4: reset in 4th SHIFT_HI aborts with no latch
    @(negedge clk); start = 1'b1; data = 8'hFF;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 16; k++) @(negedge clk);
    chk("t4_hi4", {sr_clk, sr_data, busy}, 3'b111);
    reset_n = 1'b0;
    #1 chk("t4_rst_outs", {busy, done, sr_data, sr_clk, sr_latch}, 5'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lc = 0; bc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sr_latch) lc++;
      if (busy || done) bc++;
    end
    chk("t4_no_latch", lc, 0);
    chk("t4_no_busy",  bc, 0);
    xfer_checks("t4b", 8'h96, -10);
    repeat (2) @(negedge clk);

    // 5: single set bit shows bit order
    xfer_checks("t5", 8'h01, -10);

    // 6: DATA_W=1, CLK_DIV=1 corner
    d1 = -1; hc = 0; lc = 0; r2 = -1; pc = 1'b0;
    @(negedge clk); start1 = 1'b1; data1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; data1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sr_clk1 && !pc) r2 = int'(sr_data1);
      pc = sr_clk1;
      if (sr_clk1) hc++;
      if (sr_latch1) lc++;
      if (done1) begin d1 = k; break; end
    end
    chk("t6_bit",     r2, 1);
    chk("t6_clk_hi",  hc, 1);
    chk("t6_lat_cyc", lc, 1);
    chk("t6_done_at", d1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
